// File: rtl/etapa_ex_mem_pkg.sv
// Shared definitions for the execute stage: ALUOp and funct encodings,
// multiplier FSM states and the M/WB control bundle.
package etapa_ex_mem_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;
  localparam logic [5:0] FUNCT_MULT = 6'h18;
  localparam logic [5:0] FUNCT_MFHI = 6'h10;
  localparam logic [5:0] FUNCT_MFLO = 6'h12;

  typedef enum logic [1:0] {
    MULT_IDLE = 2'd0,
    MULT_BUSY = 2'd1,
    MULT_DONE = 2'd2
  } mult_state_t;

  typedef struct packed {
    logic branch;
    logic mem_write;
    logic mem_read;
    logic mem_to_reg;
    logic reg_write;
  } mwb_ctrl_t;

endpackage

// File: rtl/ex_mult_seq.sv
// Sequential signed multiplier (one shift-add step per cycle) owning HI/LO.
// state | meaning
// IDLE  | waiting for a MULT; latches operand magnitudes and sign on start
// BUSY  | NBITS shift-add iterations
// DONE  | applies the sign and writes HI:LO
module ex_mult_seq
  import etapa_ex_mem_pkg::*;
#(
  parameter int NBITS = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_req,
  input  logic [NBITS-1:0] i_a,
  input  logic [NBITS-1:0] i_b,
  output logic             o_start,
  output logic             o_busy,
  output logic             o_done,
  output logic [NBITS-1:0] o_hi,
  output logic [NBITS-1:0] o_lo
);

  localparam int CW = $clog2(NBITS);

  mult_state_t        r_state;
  logic [2*NBITS-1:0] r_mcand;
  logic [2*NBITS-1:0] r_acc;
  logic [NBITS-1:0]   r_mplier;
  logic [NBITS-1:0]   r_hi;
  logic [NBITS-1:0]   r_lo;
  logic [CW-1:0]      r_cnt;
  logic               r_sign;

  logic [NBITS-1:0]   w_abs_a;
  logic [NBITS-1:0]   w_abs_b;
  logic               w_start;

  // Negating the most negative value wraps to itself, which is the correct unsigned magnitude.
  assign w_abs_a = i_a[NBITS-1] ? -i_a : i_a;
  assign w_abs_b = i_b[NBITS-1] ? -i_b : i_b;
  assign w_start = (r_state == MULT_IDLE) && i_req;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state  <= MULT_IDLE;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_cnt    <= '0;
      r_sign   <= 1'b0;
    end else begin
      case (r_state)
        MULT_IDLE: begin
          if (w_start) begin
            r_mcand  <= {{NBITS{1'b0}}, w_abs_a};
            r_mplier <= w_abs_b;
            r_sign   <= i_a[NBITS-1] ^ i_b[NBITS-1];
            r_acc    <= '0;
            r_cnt    <= '0;
            r_state  <= MULT_BUSY;
          end
        end
        MULT_BUSY: begin
          if (r_mplier[0]) begin
            r_acc <= r_acc + r_mcand;
          end
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
          if (r_cnt == CW'(NBITS-1)) begin
            r_state <= MULT_DONE;
          end
        end
        MULT_DONE: begin
          {r_hi, r_lo} <= r_sign ? -r_acc : r_acc;
          r_state      <= MULT_IDLE;
        end
        default: r_state <= MULT_IDLE;
      endcase
    end
  end

  assign o_start = w_start;
  assign o_busy  = (r_state == MULT_BUSY);
  assign o_done  = (r_state == MULT_DONE);
  assign o_hi    = r_hi;
  assign o_lo    = r_lo;

endmodule

// File: rtl/etapa_ex_mem.sv
// Execute stage and EX/MEM pipeline register: ALU, operand/RegDst muxes,
// branch adder, and the stall/bubble interface to the sequential multiplier.
module etapa_ex_mem
  import etapa_ex_mem_pkg::*;
#(
  parameter int NBITS  = 32,
  parameter int RNBITS = 5
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [NBITS-1:0]  i_PC4,
  input  logic [NBITS-1:0]  i_Registro1,
  input  logic [NBITS-1:0]  i_Registro2,
  input  logic [NBITS-1:0]  i_Extension,
  input  logic [RNBITS-1:0] i_Rt,
  input  logic [RNBITS-1:0] i_Rd,
  input  logic              i_ALUSrc,
  input  logic [1:0]        i_ALUOp,
  input  logic              i_RegDst,
  input  logic              i_Branch,
  input  logic              i_MemWrite,
  input  logic              i_MemRead,
  input  logic              i_MemToReg,
  input  logic              i_RegWrite,
  output logic              o_Stall,
  output logic [NBITS-1:0]  o_PCBranch,
  output logic              o_Zero,
  output logic [NBITS-1:0]  o_ALUResult,
  output logic [NBITS-1:0]  o_Registro2,
  output logic [RNBITS-1:0] o_RegDest,
  output logic              o_Branch,
  output logic              o_MemWrite,
  output logic              o_MemRead,
  output logic              o_MemToReg,
  output logic              o_RegWrite
);

  logic [NBITS-1:0]  w_b;
  logic [5:0]        w_funct;
  logic [NBITS-1:0]  w_alu;
  logic              w_slt;
  logic [NBITS-1:0]  w_pc_branch;
  logic [RNBITS-1:0] w_dest;
  logic              w_mult_req;
  logic              w_mult_start;
  logic              w_mult_busy;
  logic              w_mult_done;
  logic [NBITS-1:0]  w_hi;
  logic [NBITS-1:0]  w_lo;
  logic              w_stall;
  logic              w_bubble;
  mwb_ctrl_t         w_ctrl;

  logic [NBITS-1:0]  r_pc_branch;
  logic              r_zero;
  logic [NBITS-1:0]  r_alu;
  logic [NBITS-1:0]  r_reg2;
  logic [RNBITS-1:0] r_dest;
  mwb_ctrl_t         r_ctrl;

  assign w_b         = i_ALUSrc ? i_Extension : i_Registro2;
  assign w_funct     = i_Extension[5:0];
  assign w_slt       = $signed(i_Registro1) < $signed(w_b);
  assign w_pc_branch = i_PC4 + {i_Extension[NBITS-3:0], 2'b00};
  assign w_dest      = i_RegDst ? i_Rd : i_Rt;
  assign w_mult_req  = (i_ALUOp == ALUOP_FUNCT) && (w_funct == FUNCT_MULT);
  assign w_ctrl      = '{branch: i_Branch, mem_write: i_MemWrite, mem_read: i_MemRead,
                         mem_to_reg: i_MemToReg, reg_write: i_RegWrite};

  always_comb begin
    w_alu = '0;
    case (i_ALUOp)
      ALUOP_ADD: w_alu = i_Registro1 + w_b;
      ALUOP_SUB: w_alu = i_Registro1 - w_b;
      ALUOP_OR:  w_alu = i_Registro1 | w_b;
      default: begin
        case (w_funct)
          FUNCT_ADD:  w_alu = i_Registro1 + w_b;
          FUNCT_SUB:  w_alu = i_Registro1 - w_b;
          FUNCT_AND:  w_alu = i_Registro1 & w_b;
          FUNCT_OR:   w_alu = i_Registro1 | w_b;
          FUNCT_SLT:  w_alu = {{(NBITS-1){1'b0}}, w_slt};
          FUNCT_MFHI: w_alu = w_hi;
          FUNCT_MFLO: w_alu = w_lo;
          default:    w_alu = '0;
        endcase
      end
    endcase
  end

  ex_mult_seq #(
    .NBITS (NBITS)
  ) u_mult (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_req   (w_mult_req),
    .i_a     (i_Registro1),
    .i_b     (i_Registro2),
    .o_start (w_mult_start),
    .o_busy  (w_mult_busy),
    .o_done  (w_mult_done),
    .o_hi    (w_hi),
    .o_lo    (w_lo)
  );

  // The FSM sits in IDLE during reset, so a presented MULT would otherwise raise stall.
  assign w_stall  = i_reset && (w_mult_start || w_mult_busy);
  assign w_bubble = w_stall || w_mult_done;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_pc_branch <= '0;
      r_zero      <= 1'b0;
      r_alu       <= '0;
      r_reg2      <= '0;
      r_dest      <= '0;
      r_ctrl      <= '0;
    end else if (w_bubble) begin
      r_pc_branch <= '0;
      r_zero      <= 1'b0;
      r_alu       <= '0;
      r_reg2      <= '0;
      r_dest      <= '0;
      r_ctrl      <= '0;
    end else begin
      r_pc_branch <= w_pc_branch;
      r_zero      <= (w_alu == '0);
      r_alu       <= w_alu;
      r_reg2      <= i_Registro2;
      r_dest      <= w_dest;
      r_ctrl      <= w_ctrl;
    end
  end

  assign o_Stall     = w_stall;
  assign o_PCBranch  = r_pc_branch;
  assign o_Zero      = r_zero;
  assign o_ALUResult = r_alu;
  assign o_Registro2 = r_reg2;
  assign o_RegDest   = r_dest;
  assign o_Branch    = r_ctrl.branch;
  assign o_MemWrite  = r_ctrl.mem_write;
  assign o_MemRead   = r_ctrl.mem_read;
  assign o_MemToReg  = r_ctrl.mem_to_reg;
  assign o_RegWrite  = r_ctrl.reg_write;

endmodule
